// File: rtl/pulse_seq_pkg.sv
// Shared types and default timing for the RF pulse sequencer: state encoding,
// mode encoding, and 66.6 MHz default segment lengths.
package pulse_seq_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    P1    = 3'd2,
    GAP1  = 3'd3,
    P2    = 3'd4,
    GAP2  = 3'd5,
    P3    = 3'd6,
    HOLD  = 3'd7
  } state_t;

  localparam logic MODE_MZ   = 1'b0;
  localparam logic MODE_RABI = 1'b1;

  localparam int DEF_START_CYC   = 400;
  localparam int DEF_PI_2_CYC    = 333;
  localparam int DEF_PI_CYC      = 666;
  localparam int DEF_T_CYC       = 66600;
  localparam int DEF_HOLDOFF_CYC = 33300;

endpackage

// File: rtl/pulse_sequencer_if.sv
// Trigger/status bundle between the MCU side (master) and the pulse sequencer
// (slave).
interface pulse_sequencer_if #(
  parameter int CNT_W  = 32,
  parameter int SHOT_W = 16
);
  logic              trig;
  logic              mode;
  logic              abort;
  logic              rabi_clr;
  logic              rf;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  rabi_len;
  logic [SHOT_W-1:0] shot_count;

  modport master (
    output trig, mode, abort, rabi_clr,
    input  rf, busy, done, rabi_len, shot_count
  );

  modport slave (
    input  trig, mode, abort, rabi_clr,
    output rf, busy, done, rabi_len, shot_count
  );
endinterface

// File: rtl/sync_edge_det.sv
// Optional 2-flop synchroniser (PULSE_SEQUENCER_TRIG_SYNC_EN) followed by a
// rising-edge detector; EDGE=0 passes the (synchronised) level through instead.
module sync_edge_det #(
  parameter bit EDGE = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic s;
  logic prev;

`ifdef PULSE_SEQUENCER_TRIG_SYNC_EN
  logic [1:0] sync;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync <= 2'b00;
    else     sync <= {sync[0], d};
  end
  assign s = sync[1];
`else
  assign s = d;
`endif

  // History is tracked every cycle, so a held-high input never re-fires.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev <= 1'b0;
    else     prev <= s;
  end

  assign q = s & ~(prev & EDGE);
endmodule

// File: rtl/pulse_sequencer.sv
// RF pulse sequencer: Mach-Zehnder (pi/2-T-pi-T-pi/2) or stepped-length Rabi
// shots on one gate output. PULSE_SEQUENCER_TRIG_SYNC_EN adds input synchronisers.
module pulse_sequencer
  import pulse_seq_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int START_CYC   = DEF_START_CYC,
  parameter int PI_2_CYC    = DEF_PI_2_CYC,
  parameter int PI_CYC      = DEF_PI_CYC,
  parameter int T_CYC       = DEF_T_CYC,
  parameter int HOLDOFF_CYC = DEF_HOLDOFF_CYC,
  parameter int RABI_INIT   = 66,
  parameter int RABI_STEP   = 66,
  parameter int RABI_MAX    = 66000,
  parameter int SHOT_W      = 16
) (
  input logic              clk,
  input logic              rst,
  pulse_sequencer_if.slave bus
);
  state_t            state, state_d;
  logic [CNT_W-1:0]  cnt, cnt_d, seg_len;
  logic [CNT_W-1:0]  shot_len, rabi_len_q, rabi_next;
  logic [CNT_W:0]    rabi_sum;
  logic [SHOT_W-1:0] shot_q;
  logic              shot_mode;
  logic              rf_q, busy_q, done_q;
  logic              rf_d, busy_d, done_d;
  logic              seg_end, start, abort_lvl;

  sync_edge_det #(.EDGE(1'b1)) u_trig  (.clk(clk), .rst(rst), .d(bus.trig),  .q(start));
  sync_edge_det #(.EDGE(1'b0)) u_abort (.clk(clk), .rst(rst), .d(bus.abort), .q(abort_lvl));

  always_comb begin
    seg_len = '0;
    unique case (state)
      START:       seg_len = CNT_W'(START_CYC);
      P1:          seg_len = (shot_mode == MODE_RABI) ? shot_len : CNT_W'(PI_2_CYC);
      GAP1, GAP2:  seg_len = CNT_W'(T_CYC);
      P2:          seg_len = CNT_W'(PI_CYC);
      P3:          seg_len = CNT_W'(PI_2_CYC);
      HOLD:        seg_len = CNT_W'(HOLDOFF_CYC);
      default:     seg_len = '0;
    endcase
  end

  assign seg_end = (cnt == seg_len - CNT_W'(1));

  // Extra bit keeps the step add from wrapping before the limit compare.
  assign rabi_sum  = {1'b0, rabi_len_q} + (CNT_W+1)'(RABI_STEP);
  assign rabi_next = (rabi_sum > (CNT_W+1)'(RABI_MAX)) ? CNT_W'(RABI_INIT)
                                                       : rabi_sum[CNT_W-1:0];

  // NOTE: every output gets a default first; a path leaving one unassigned would infer a latch.
  always_comb begin
    state_d = state;
    cnt_d   = cnt + CNT_W'(1);
    done_d  = 1'b0;
    if (state == IDLE) begin
      cnt_d = '0;
      if (start) state_d = START;
    end else if (abort_lvl) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (seg_end) begin
      cnt_d = '0;
      unique case (state)
        START:   state_d = P1;
        P1:      state_d = (shot_mode == MODE_RABI) ? HOLD : GAP1;
        GAP1:    state_d = P2;
        P2:      state_d = GAP2;
        GAP2:    state_d = P3;
        P3:      state_d = HOLD;
        HOLD: begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
    rf_d   = (state_d == P1) || (state_d == P2) || (state_d == P3);
    busy_d = (state_d != IDLE);
  end

  // NOTE: non-blocking throughout so every flop samples the same pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      rf_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      shot_q     <= '0;
      rabi_len_q <= CNT_W'(RABI_INIT);
      shot_len   <= CNT_W'(RABI_INIT);
      shot_mode  <= MODE_MZ;
    end else begin
      state  <= state_d;
      cnt    <= cnt_d;
      rf_q   <= rf_d;
      busy_q <= busy_d;
      done_q <= done_d;
      if (state == IDLE && start) begin
        shot_len  <= rabi_len_q;
        shot_mode <= bus.mode;
      end
      if (done_d) shot_q <= shot_q + SHOT_W'(1);
      if (bus.rabi_clr)
        rabi_len_q <= CNT_W'(RABI_INIT);
      else if (done_d && shot_mode == MODE_RABI)
        rabi_len_q <= rabi_next;
    end
  end

  assign bus.rf         = rf_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.rabi_len   = rabi_len_q;
  assign bus.shot_count = shot_q;
endmodule

// File: tb/tb_pulse_sequencer.sv
// Directed bench for pulse_sequencer with shortened timing: MZ, stepped and
// wrapping Rabi, retrigger, abort, rabi_clr and asynchronous reset scenarios.
module tb_pulse_sequencer;
  import pulse_seq_pkg::*;

`ifdef PULSE_SEQUENCER_TRIG_SYNC_EN
  localparam int L = 2;
`else
  localparam int L = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  pulse_sequencer_if #(.CNT_W(32), .SHOT_W(16)) bus ();

  pulse_sequencer #(
    .CNT_W(32), .START_CYC(4), .PI_2_CYC(3), .PI_CYC(6), .T_CYC(10),
    .HOLDOFF_CYC(5), .RABI_INIT(2), .RABI_STEP(2), .RABI_MAX(10), .SHOT_W(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  logic rf_h   [0:127];
  logic busy_h [0:127];
  logic done_h [0:127];
  int   p_start [0:7];
  int   p_len   [0:7];
  int   n_pulses, done_cnt, done_idx, busy_first, busy_fall;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Start a shot from a negedge and record rf/busy/done for n cycles.
  task automatic capture(input int n, input logic m, input int drop_at, input int rise_at,
                         input int abort_at, input int clr_at);
    bus.mode = m;
    bus.trig = 1'b1;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      rf_h[i]   = bus.rf;
      busy_h[i] = bus.busy;
      done_h[i] = bus.done;
      if (i == 1 || i == abort_at + 1) bus.abort = 1'b0;
      if (i == abort_at) bus.abort = 1'b1;
      bus.rabi_clr = (i == clr_at);
      if (i == drop_at) bus.trig = 1'b0;
      if (i == rise_at) bus.trig = 1'b1;
    end
    bus.trig = 1'b0; bus.abort = 1'b0; bus.rabi_clr = 1'b0;
    repeat (4) @(negedge clk);
    n_pulses = 0; done_cnt = 0; done_idx = -1; busy_first = -1; busy_fall = -1;
    for (int i = 1; i <= n; i++) begin
      if (rf_h[i] && (i == 1 || !rf_h[i-1]) && n_pulses < 8) begin
        p_start[n_pulses] = i;
        p_len[n_pulses]   = 0;
        n_pulses++;
      end
      if (rf_h[i] && n_pulses > 0) p_len[n_pulses-1]++;
      if (done_h[i]) begin
        done_cnt++;
        if (done_idx < 0) done_idx = i;
      end
      if (busy_h[i] && busy_first < 0) busy_first = i;
      if (!busy_h[i] && busy_first >= 0 && busy_fall < 0) busy_fall = i;
    end
  endtask

  task automatic check_mz(input string t);
    check({t, "_npulse"},  n_pulses, 3);
    check({t, "_p1_at"},   p_start[0], 5 + L);
    check({t, "_p1_len"},  p_len[0], 3);
    check({t, "_p2_at"},   p_start[1], 18 + L);
    check({t, "_p2_len"},  p_len[1], 6);
    check({t, "_p3_at"},   p_start[2], 34 + L);
    check({t, "_p3_len"},  p_len[2], 3);
    check({t, "_done_at"}, done_idx, 42 + L);
    check({t, "_ndone"},   done_cnt, 1);
    check({t, "_busy_on"}, busy_first, 1 + L);
    check({t, "_busy_off"}, busy_fall, 42 + L);
  endtask

  task automatic check_rabi(input string t, input int w);
    check({t, "_npulse"},  n_pulses, 1);
    check({t, "_at"},      p_start[0], 5 + L);
    check({t, "_len"},     p_len[0], w);
    check({t, "_done_at"}, done_idx, 10 + w + L);
    check({t, "_ndone"},   done_cnt, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.trig = 1'b0; bus.mode = MODE_MZ; bus.abort = 1'b0; bus.rabi_clr = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_rf", bus.rf, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_rabi_len", bus.rabi_len, 2);
    check("rst_shots", bus.shot_count, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Abort in IDLE does nothing.
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    repeat (4) @(negedge clk);
    check("idle_abort_busy", bus.busy, 0);
    check("idle_abort_shots", bus.shot_count, 0);

    // One full MZ shot.
    capture(50 + L, MODE_MZ, 3, -1, -1, -1);
    check_mz("mz1");
    check("mz1_shots", bus.shot_count, 1);
    check("mz1_rabi_len", bus.rabi_len, 2);

    // Stepped Rabi shots: 2,4,6,8 then 10 at the limit, then wrap to INIT.
    for (int k = 0; k < 5; k++) begin
      capture(14 + (2 + 2*k) + L, MODE_RABI, 3, -1, -1, -1);
      check_rabi($sformatf("rabi%0d", k), 2 + 2*k);
      if (k == 3) check("rabi_len_after4", bus.rabi_len, 10);
    end
    check("rabi_len_wrapped", bus.rabi_len, 2);
    check("rabi_shots", bus.shot_count, 6);

    // Retrigger during GAP1 and hold high past completion: no second shot.
    capture(75 + L, MODE_MZ, 3, 12 + L, -1, -1);
    check("retrig_npulse", n_pulses, 3);
    check("retrig_ndone", done_cnt, 1);
    check("retrig_idle", busy_h[75 + L], 0);
    capture(50 + L, MODE_MZ, 3, -1, -1, -1);
    check_mz("fresh");
    check("fresh_shots", bus.shot_count, 8);

    // Abort in the middle of P2.
    capture(50 + L, MODE_MZ, 3, -1, 18 + L, -1);
    check("abort_npulse", n_pulses, 2);
    check("abort_p2_len", p_len[1], 1 + L);
    check("abort_rf_late", rf_h[18 + 2*L], 1);
    check("abort_rf_off", rf_h[19 + 2*L], 0);
    check("abort_busy_off", busy_h[19 + 2*L], 0);
    check("abort_ndone", done_cnt, 0);
    check("abort_shots", bus.shot_count, 8);
    check("abort_rabi_len", bus.rabi_len, 2);

    // Start edge coinciding with abort in IDLE: the start wins.
    bus.abort = 1'b1;
    capture(50 + L, MODE_MZ, 3, -1, -1, -1);
    check_mz("abort_start");
    check("abort_start_shots", bus.shot_count, 9);

    // rabi_clr: mid-shot keeps the latched length; at completion it beats the step.
    capture(16 + L, MODE_RABI, 3, -1, -1, -1);
    check_rabi("r6", 2);
    check("r6_len_next", bus.rabi_len, 4);
    capture(18 + L, MODE_RABI, 3, -1, -1, 6 + L);
    check_rabi("r7_midclr", 4);
    check("r7_len_next", bus.rabi_len, 4);
    capture(18 + L, MODE_RABI, 3, -1, -1, 13 + L);
    check_rabi("r8_endclr", 4);
    check("r8_len_next", bus.rabi_len, 2);
    check("r8_shots", bus.shot_count, 12);

    // Asynchronous reset in the middle of P1.
    bus.mode = MODE_MZ;
    bus.trig = 1'b1;
    repeat (6 + L) @(negedge clk);
    check("prerst_rf", bus.rf, 1);
    #2 rst = 1'b1;
    #1;
    check("midrst_rf", bus.rf, 0);
    check("midrst_busy", bus.busy, 0);
    check("midrst_rabi_len", bus.rabi_len, 2);
    check("midrst_shots", bus.shot_count, 0);
    @(negedge clk);
    rst = 1'b0;
    bus.trig = 1'b0;
    repeat (4) @(negedge clk);
    capture(16 + L, MODE_RABI, 3, -1, -1, -1);
    check_rabi("post_rst", 2);
    check("post_rst_shots", bus.shot_count, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pulse_sequencer.md
Name: pulse_sequencer

Overview:
Parametrised RF pulse sequencer for atom-interferometry shots. It drives a single RF gate output in one of two modes:
- Mach-Zehnder: pi/2 - T - pi - T - pi/2.
- Rabi: a single pulse whose length steps up on every completed shot.

It supersedes the separate free-running MZ and Rabi processes. It adds edge-triggered start, abort, busy/done status and a shot counter, and sits between the MCU trigger pins and the RF switch driver.

Parameters:
CNT_W, 32, width of the segment counter and of the Rabi length register
START_CYC, 400, dead time between trigger and first pulse (cycles, >=1)
PI_2_CYC, 333, pi/2 pulse length (cycles, >=1)
PI_CYC, 666, pi pulse length (cycles, >=1)
T_CYC, 66600, free-evolution interval between MZ pulses (cycles, >=1)
HOLDOFF_CYC, 33300, post-shot lockout so the MCU can release the trigger (cycles, >=1)
RABI_INIT, 66, first Rabi pulse length (cycles, >=1)
RABI_STEP, 66, Rabi length increment per completed shot
RABI_MAX, 66000, largest Rabi length before wrap
SHOT_W, 16, shot counter width

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
trig  in  1  shot request; rising edge starts a shot
mode  in  1  0 = Mach-Zehnder, 1 = Rabi; sampled on the start edge only
abort  in  1  synchronous abort of the shot in progress
rabi_clr  in  1  reload the Rabi length with RABI_INIT
rf  out  1  registered RF gate
busy  out  1  high from the start edge through the end of HOLDOFF
done  out  1  one-cycle pulse on normal completion
rabi_len  out  CNT_W  Rabi length the next Rabi shot will use
shot_count  out  SHOT_W  completed shots since reset

Behaviour:
- Reset (async, rst=1): state IDLE, rf=0, busy=0, done=0, counter=0, rabi_len=RABI_INIT, shot_count=0, trig history=0.
- Start condition:
  - A start edge is trig=1 with previous sample 0, while in IDLE.
  - Edges in any other state are ignored.
  - Holding trig high never retriggers.
- States: IDLE, START, P1, GAP1, P2, GAP2, P3, HOLD.
  - MZ path: START->P1->GAP1->P2->GAP2->P3->HOLD->IDLE.
  - Rabi path: START->P1->HOLD->IDLE.
- Segment lengths (each segment lasts exactly its stated cycle count; counter runs 0..N-1 and resets on every transition):
  - START = START_CYC.
  - P1 = PI_2_CYC (MZ) or the latched rabi_len (Rabi).
  - GAP1 = T_CYC, P2 = PI_CYC, GAP2 = T_CYC, P3 = PI_2_CYC.
  - HOLD = HOLDOFF_CYC.
- rf: registered; high exactly during P1, P2 and P3. First rf=1 cycle is START_CYC+1 cycles after the start-edge sample.
- busy: registered; goes 1 on the cycle after the start edge and returns to 0 on entry to IDLE.
- done: asserted for 1 cycle on the HOLD->IDLE transition.
- shot_count: increments by 1 on that same HOLD->IDLE transition and wraps modulo 2^SHOT_W.
- Rabi length:
  - Latched into a shot-local register at the start edge.
  - On Rabi completion: rabi_len <= rabi_len+RABI_STEP, but if that sum > RABI_MAX then rabi_len <= RABI_INIT.
  - The add is computed at CNT_W+1 bits so it cannot overflow.
  - MZ shots leave rabi_len unchanged.
- rabi_clr:
  - Takes effect next cycle in any state; the shot in progress keeps its latched length.
  - If rabi_clr coincides with the Rabi completion update, rabi_clr wins.
- abort (any non-IDLE state):
  - Next cycle: state=IDLE, rf=0, busy=0.
  - No done pulse, no shot_count increment, rabi_len not stepped.
  - abort in IDLE has no effect.
  - If abort and a start edge occur in the same cycle while in IDLE, the start is taken.
- Mid-operation rst: immediate return to the reset values. rf drops asynchronously.

Optional Feature:
- Macro: PULSE_SEQUENCER_TRIG_SYNC_EN.
- Defined: trig and abort each pass through a 2-flop synchroniser before edge detection. Every trig/abort-to-response latency grows by exactly 2 cycles.
- Undefined: inputs are used directly and must already be synchronous to clk.

Decomposition:
- Shared package pulse_seq_pkg holds:
  - the state enum (IDLE..HOLD);
  - mode encoding constants MODE_MZ=0, MODE_RABI=1;
  - default timing constants for 66.6 MHz clk (PI_2=333, PI=666, T=66600, HOLD=33300).
- One sub-module, sync_edge_det: optional 2-flop synchroniser plus rising-edge detector, instantiated for trig and reused for abort (level output).

Test Plan:
- MZ shot, default params: trig 0->1 -> rf high for 333 cycles starting START_CYC+1=401 cycles after the edge sample, low 66600, high 666, low 66600, high 333. busy drops and done pulses 33300 cycles after the last rf fall. shot_count=1.
- Four consecutive Rabi shots, RABI_STEP=66 -> rf widths 66, 132, 198, 264. rabi_len reads 330 afterwards.
- Rabi wrap, RABI_INIT=66, STEP=66, MAX=200 -> widths 66, 132, 198, 66.
- Trig retriggered during GAP1 and held high through completion -> no second shot. A fresh 0->1 edge after IDLE starts one.
- abort mid-P2 -> rf=0 and busy=0 next cycle, no done, shot_count unchanged. A following shot runs the full MZ sequence.
- rst asserted mid-P1 -> rf=0 immediately (async). rabi_len=66, shot_count=0. With PULSE_SEQUENCER_TRIG_SYNC_EN defined, every latency in the scenarios above is +2 cycles.
